// File: rtl/display_7seg_mux_pkg.sv
// Shared constants for the multiplexed seven-segment driver: blank pattern,
// PWM period limit and the active-low hex glyph table {g,f,e,d,c,b,a}.
package display_pkg;

  localparam logic [6:0] SEG_BLANK = 7'h7F;
  localparam logic [3:0] PWM_MAX   = 4'd14;

  // Entry [h] is the glyph for hex digit h (index 15 written first).
  localparam logic [15:0][6:0] GLYPH = {
    7'b0001110,  // F
    7'b0000110,  // E
    7'b0100001,  // d
    7'b1000110,  // C
    7'b0000011,  // b
    7'b0001000,  // A
    7'b0010000,  // 9
    7'b0000000,  // 8
    7'b1111000,  // 7
    7'b0000010,  // 6
    7'b0010010,  // 5
    7'b0011001,  // 4
    7'b0110000,  // 3
    7'b0100100,  // 2
    7'b1111001,  // 1
    7'b1000000   // 0
  };

  function automatic logic [6:0] hex2seg(input logic [3:0] h);
    return GLYPH[h];
  endfunction

endpackage

// File: rtl/display_7seg_mux_hex7seg_dec.sv
// Combinational nibble to active-low seven-segment decoder.
module hex7seg_dec
  import display_pkg::*;
(
  input  logic [3:0] hex,
  output logic [6:0] seg
);

  assign seg = hex2seg(hex);

endmodule

// File: rtl/display_7seg_mux.sv
// Time-multiplexed seven-segment driver with double-buffered, tear-free
// frame updates, leading-zero blanking and PWM brightness control.
module display_7seg_mux
  import display_pkg::*;
#(
  parameter int N_DIGITS    = 8,
  parameter int REFRESH_DIV = 100000
) (
  input  logic                    clk_i,
  input  logic                    reset_i,
  input  logic [4*N_DIGITS-1:0]   dato_i,
  input  logic [N_DIGITS-1:0]     dp_i,
  input  logic                    load_i,
  input  logic                    blank_lz_i,
  input  logic [3:0]              brightness_i,
  output logic [N_DIGITS-1:0]     an_o,
  output logic [6:0]              seg_o,
  output logic                    dp_o,
  output logic                    pending_o,
  output logic                    frame_o
);

  localparam int PW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam int IW = $clog2(N_DIGITS);

  logic [PW-1:0]                   presc;
  logic [IW-1:0]                   idx;
  logic [3:0]                      pwm_cnt;
  logic [4*N_DIGITS-1:0]           pend_dat, disp_dat;
  logic [N_DIGITS-1:0]             pend_dp, disp_dp;
  logic                            tick, frame_b;
  logic [N_DIGITS-1:0][6:0]        dig_seg, dig_seg_b;

  assign tick    = (presc == PW'(REFRESH_DIV - 1));
  assign frame_b = tick && (idx == IW'(N_DIGITS - 1));

  // One decoder per digit; a digit is blanked when it and every more
  // significant nibble are zero. Digit 0 always shows.
  for (genvar k = 0; k < N_DIGITS; k++) begin : g_dig
    hex7seg_dec u_dec (
      .hex (disp_dat[4*k +: 4]),
      .seg (dig_seg[k])
    );
    if (k == 0) begin : g_lsd
      assign dig_seg_b[k] = dig_seg[k];
    end else begin : g_msd
      assign dig_seg_b[k] = (blank_lz_i && (disp_dat[4*N_DIGITS-1:4*k] == '0))
                            ? SEG_BLANK : dig_seg[k];
    end
  end

  // Slot prescaler, digit index and PWM phase counters.
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      presc   <= '0;
      idx     <= '0;
      pwm_cnt <= '0;
    end else begin
      presc   <= tick ? '0 : presc + PW'(1);
      if (tick)
        idx   <= (idx == IW'(N_DIGITS - 1)) ? '0 : idx + IW'(1);
      pwm_cnt <= (pwm_cnt == PWM_MAX) ? '0 : pwm_cnt + 4'd1;
    end
  end

  // Double buffer: loads park in the pending buffer and only reach the
  // display buffer at a frame boundary; a load on the boundary goes straight in.
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      pend_dat  <= '0;
      pend_dp   <= '0;
      disp_dat  <= '0;
      disp_dp   <= '0;
      pending_o <= 1'b0;
    end else begin
      if (load_i) begin
        pend_dat <= dato_i;
        pend_dp  <= dp_i;
      end
      if (frame_b) begin
        if (load_i) begin
          disp_dat <= dato_i;
          disp_dp  <= dp_i;
        end else if (pending_o) begin
          disp_dat <= pend_dat;
          disp_dp  <= pend_dp;
        end
        pending_o <= 1'b0;
      end else if (load_i) begin
        pending_o <= 1'b1;
      end
    end
  end

  // Registered pad drivers; the anode is gated by the PWM duty window.
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      an_o    <= '1;
      seg_o   <= SEG_BLANK;
      dp_o    <= 1'b1;
      frame_o <= 1'b0;
    end else begin
      an_o    <= (pwm_cnt < brightness_i) ? ~(N_DIGITS'(1) << idx) : '1;
      seg_o   <= dig_seg_b[idx];
      dp_o    <= ~disp_dp[idx];
      frame_o <= frame_b;
    end
  end

endmodule

// File: doc/display_7seg_mux.md
DISPLAY_7SEG_MUX -- requirements
Module: display_7seg_mux

Interface
REQ-001 The block SHALL have parameter N_DIGITS, default 8, giving the number of multiplexed digits (legal range 2..16).
REQ-002 The block SHALL have parameter REFRESH_DIV, default 100000, giving the clock cycles per digit slot (legal minimum 2).
REQ-003 The block SHALL have port clk_i, input, 1 bit, system clock; all state SHALL be on its rising edge.
REQ-004 The block SHALL have port reset_i, input, 1 bit, asynchronous active-high reset.
REQ-005 The block SHALL have port dato_i, input, 4*N_DIGITS bits, hex value; nibble k drives digit k, with nibble 0 as the LSB.
REQ-006 The block SHALL have port dp_i, input, N_DIGITS bits, decimal-point request per digit, active-high.
REQ-007 The block SHALL have port load_i, input, 1 bit, single-cycle strobe that captures dato_i and dp_i.
REQ-008 The block SHALL have port blank_lz_i, input, 1 bit, leading-zero blanking enable.
REQ-009 The block SHALL have port brightness_i, input, 4 bits, duty level; 0 means off and 15 means fully on.
REQ-010 The block SHALL have port an_o, output, N_DIGITS bits, digit anodes, active-low.
REQ-011 The block SHALL have port seg_o, output, 7 bits, segments {g,f,e,d,c,b,a}, active-low.
REQ-012 The block SHALL have port dp_o, output, 1 bit, decimal-point segment, active-low.
REQ-013 The block SHALL have port pending_o, output, 1 bit, high while a loaded value waits for a frame boundary.
REQ-014 The block SHALL have port frame_o, output, 1 bit, one-cycle pulse at each frame wrap.

Function
REQ-015 The prescaler SHALL count 0..REFRESH_DIV-1 and wrap; the cycle in which it equals REFRESH_DIV-1 SHALL be a tick.
REQ-016 The digit index SHALL advance by 1 on each tick and wrap from N_DIGITS-1 to 0.
REQ-017 A tick that occurs while the index equals N_DIGITS-1 SHALL be a frame boundary; frame_o SHALL be high in the following cycle only.
REQ-018 load_i SHALL capture dato_i and dp_i into a pending buffer and set pending_o in the next cycle.
REQ-019 At a frame boundary with pending set, the pending buffer SHALL copy into the display buffer and pending_o SHALL clear, so no frame is ever torn.
REQ-020 If load_i coincides with a frame boundary, the display buffer SHALL take the current dato_i/dp_i directly and pending_o SHALL be 0 afterwards.
REQ-021 A load_i arriving while pending is already set SHALL overwrite the pending buffer; the last load wins.
REQ-022 Segment decoding SHALL use the standard hex glyphs 0-9, A, b, C, d, E, F, active-low (e.g. 0 = 7'b1000000, F = 7'b0001110).
REQ-023 With blank_lz_i=1, digit k (k>0) SHALL be blanked (seg_o = 7'h7F) when nibbles k..N_DIGITS-1 are all zero; digit 0 SHALL never be blanked.
REQ-024 dp_o SHALL equal ~dp bit of the active digit, regardless of blanking.
REQ-025 A 4-bit PWM counter SHALL count 0..14 every cycle and wrap; the active anode SHALL be driven low only when pwm_cnt < brightness_i, otherwise all of an_o SHALL be 1.
REQ-026 brightness_i = 15 SHALL give a continuously-on active anode, and 0 SHALL keep all anodes high.
REQ-027 an_o, seg_o and dp_o SHALL be registered, each reflecting the index, buffer and PWM state of the previous cycle (latency 1).
REQ-028 Exactly one bit of an_o SHALL be low at any time, or none.

Reset
REQ-029 On reset_i, the prescaler, index, PWM counter, both buffers and pending_o SHALL be cleared to 0.
REQ-030 On reset_i, an_o SHALL be all ones, seg_o SHALL be 7'h7F, dp_o SHALL be 1 and frame_o SHALL be 0.
REQ-031 Reset asserted mid-frame SHALL discard any pending load; the first tick after release SHALL occur REFRESH_DIV cycles later.

Structure
REQ-032 Package display_pkg SHALL hold SEG_BLANK = 7'h7F, the PWM_MAX = 14 constant and the hex-to-segment glyph table.
REQ-033 A combinational sub-module hex7seg_dec (4-bit nibble in, 7-bit active-low segments out) SHALL perform the decode.

Verification (N_DIGITS=4, REFRESH_DIV=4, brightness 15 unless stated)
REQ-034 The bench SHALL cover reset then idle: an_o cycles 1110, 1101, 1011, 0111, each held 4 cycles, with seg_o = 1000000; frame_o pulses every 16 cycles.
REQ-035 The bench SHALL cover load 16'h12AF mid-frame: pending_o goes high, digits keep showing 0 until the frame boundary, then show F, A, 2, 1 and pending_o drops.
REQ-036 The bench SHALL cover two loads (16'h1111 then 16'h2222) within one frame: the next frame shows 2222 only.
REQ-037 The bench SHALL cover load 16'h0050 with blank_lz_i=1: digits 3 and 2 show 7F, digit 1 shows 5, digit 0 shows 0.
REQ-038 The bench SHALL cover brightness_i=3: the active anode is low exactly 3 of every 15 cycles; with brightness_i=0, an_o stays 1111.
REQ-039 The bench SHALL cover reset_i asserted with pending set: outputs take their reset values immediately and the old value never appears after release.
